aes_decrypt: RTL and testbench
==============================

# aes_decrypt

Iterative AES inverse cipher for 128/192/256-bit keys, one round per clock. It consumes a ciphertext block plus a pre-expanded round-key array, and returns the plaintext with a sticky done flag. It sits downstream of the AES encryptor and key-expansion logic. Its `ready` input is normally driven by the encryptor's done flag, and the two share the same `key_words` bus.

## Interface

- No parameters.
- `eph1` input 1: sole clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-low reset (asserted at 0).
- `ready` input 1: request level; a 0→1 transition (as sampled on `eph1`) starts a decryption.
- `cipher` input 128 (`[15:0][7:0]`): ciphertext. Byte 15 (bits 127:120) is state byte 0, then column-major per FIPS-197.
- `key_size` input 2: `00` = AES-128, `01` = AES-192, `1x` = AES-256.
- `key_words` input 15×128 (`[15:1][127:0]`): expanded round keys.
  - Round key r (r = 0..Nr) is at index 15−r.
  - Unused low indices are don't-care.
  - Byte order is the same as `cipher`.
- `fin_flag_r` output 1: registered done flag, sticky.
- `plain_out` output 128: registered plaintext, valid while `fin_flag_r` = 1.

## Operation

- Nr = 10 / 12 / 14 for `key_size` 00 / 01 / 1x.
- Start detect:
  - Register `ready_q`, reset value 0.
  - `start = ready & ~ready_q & (state != BUSY)`.
  - Consequence: `ready` held high through reset release starts an operation on the first clock after release.
- FSM states are IDLE, BUSY and DONE.
- IDLE/DONE + start → BUSY:
  - `state_reg ← cipher ^ key_words[15−Nr]`.
  - Latch Nr from `key_size`.
  - `round ← Nr−1`.
  - `fin_flag_r ← 0`.
- BUSY, `round` > 0 (full inverse round), applied in order:
  - InvShiftRows
  - InvSubBytes
  - AddRoundKey(`key_words[15−round]`)
  - InvMixColumns
  - then `round ← round−1`.
- BUSY, `round` = 0 (final round):
  - InvShiftRows, InvSubBytes, AddRoundKey(`key_words[15]`), no InvMixColumns.
  - Result goes to `plain_out`; `fin_flag_r ← 1`; go to DONE.
- DONE:
  - Hold `plain_out` and `fin_flag_r`.
  - `ready` staying high does not restart; `ready` must return low and rise again.
- InvSubBytes uses the FIPS-197 inverse S-box, either as a ROM or as GF(2^8) inversion plus inverse affine.
- InvMixColumns uses GF(2^8) with polynomial 0x11B and coefficients {0e, 0b, 0d, 09}.
- Input capture rules:
  - `cipher` and `key_size` are captured at start.
  - `key_words` is not captured and must stay stable until `fin_flag_r` rises.
- A rising `ready` while BUSY is ignored. No queueing; `ready_q` still tracks `ready`.

## Timing

- Reset (async, `reset` = 0) forces immediately:
  - `fin_flag_r` = 0
  - `plain_out` = 0
  - `state_reg` = 0
  - `ready_q` = 0
  - FSM = IDLE
- Latency is counted from the start edge E0 (the edge where `ready` = 1 and `ready_q` = 0).
  - `fin_flag_r` and `plain_out` become valid after edge E0+Nr: 10, 12 or 14 clocks.
- Back-to-back operation: a new start from DONE is possible at the earliest 2 clocks after done (`ready` low for ≥1 clock, then high). On that start edge `fin_flag_r` drops to 0.
- Reset asserted mid-operation aborts with no output. After release, `ready` held high starts a fresh operation.
- All outputs are flop outputs; there is no combinational path from input to output.

## Test plan

- **AES-128 (FIPS-197 C.1).**
  - Stimulus: key 000102…0f expanded into `key_words[15:5]`; `cipher` = 69c4e0d86a7b0430d8cdb78070b4c55a; `key_size` = 00; `ready` rises.
  - Required: `plain_out` = 00112233445566778899aabbccddeeff with `fin_flag_r` = 1 exactly 10 clocks after start, 0 before.
- **AES-192 (FIPS-197 C.2).**
  - Stimulus: key 000102…17, expansion in `[15:3]`; `cipher` = dda97ca4864cdfe06eaf70a0ec0d7191; `key_size` = 01.
  - Required: same plaintext after 12 clocks.
- **AES-256 (FIPS-197 C.3).**
  - Stimulus: key 000102…1f, expansion in `[15:1]`; `cipher` = 8ea2b7ca516745bfeafc49904b496089.
  - Required: same plaintext after 14 clocks with `key_size` = 10, and again with `key_size` = 11.
- **Round trip with the encryptor.**
  - Stimulus: `ready` driven by the encryptor's done flag; `cipher` = encryptor output; plaintext 27ECB2E3A5EE3894885B5289307400E3; `key_size` = 10.
  - Required: `plain_out` equals the original plaintext, and `fin_flag_r` stays high.
- **Sticky flag and restart.**
  - Stimulus: `ready` held high after done; then driven low 1 clock and high with a new `cipher`.
  - Required: no restart while `ready` stays high. On the new rise, `fin_flag_r` → 0 on that edge and returns to 1 Nr clocks later with the new result. A rise while BUSY is ignored and the result is unchanged.
- **Reset mid-operation.**
  - Stimulus: `reset` = 0 asynchronously at clock 5 of an AES-256 run.
  - Required: `plain_out` = 0 and `fin_flag_r` = 0 immediately, without waiting for a clock edge. After release with `ready` high, correct plaintext appears 14 clocks after the first post-release edge.

Source files
------------

// File: rtl/aes_decrypt.sv
// Iterative AES inverse cipher (AES-128/192/256), one inverse round per clock.
// Consumes a ciphertext plus an externally expanded round-key array and returns a sticky done flag.
module aes_decrypt (
   input  logic                eph1,
   input  logic                reset,
   input  logic                ready,
   input  logic [15:0][7:0]    cipher,
   input  logic [1:0]          key_size,
   input  logic [15:1][127:0]  key_words,
   output logic                fin_flag_r,
   output logic [127:0]        plain_out
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]   fsm;
   logic [127:0] state_reg;
   logic [3:0]   round;
   logic         ready_q;
   logic         start;
   logic [3:0]   nr_in;
   logic [127:0] rk_start;
   logic [127:0] rk_round;
   logic [127:0] round_out;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254 (product of x^2 .. x^128); maps 0 to 0 as AES requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] r;
      sq = x;
      r  = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq = gmul(sq, sq);
         r  = gmul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      logic [7:0] a;
      a = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
      return gf_inv(a);
   endfunction

   // State byte k (row k%4, column k/4) lives at bits 127-8k; byte 0 is the MSB.
   function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] rk,
                                              input logic mix);
      logic [127:0] t;
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      t = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            t[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
      t = t ^ rk;
      o = t;
      if (mix) begin
         for (int c = 0; c < 4; c++) begin
            a0 = t[127-32*c -: 8];
            a1 = t[119-32*c -: 8];
            a2 = t[111-32*c -: 8];
            a3 = t[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
         end
      end
      return o;
   endfunction

   always_comb begin
      case (key_size)
         2'b00:   nr_in = 4'd10;
         2'b01:   nr_in = 4'd12;
         default: nr_in = 4'd14;
      endcase
      start     = ready & ~ready_q & (fsm != BUSY);
      rk_start  = key_words[4'd15 - nr_in];
      rk_round  = key_words[4'd15 - round];
      round_out = inv_round(state_reg, rk_round, round != 4'd0);
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge eph1 or negedge reset) begin
      if (!reset) begin
         fsm        <= IDLE;
         state_reg  <= '0;
         round      <= '0;
         ready_q    <= 1'b0;
         fin_flag_r <= 1'b0;
         plain_out  <= '0;
      end else begin
         ready_q <= ready;
         if (start) begin
            state_reg  <= cipher ^ rk_start;
            round      <= nr_in - 4'd1;
            fin_flag_r <= 1'b0;
            fsm        <= BUSY;
         end else if (fsm == BUSY) begin
            state_reg <= round_out;
            if (round == 4'd0) begin
               plain_out  <= round_out;
               fin_flag_r <= 1'b1;
               fsm        <= DONE;
            end else begin
               round <= round - 4'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_aes_decrypt.sv
// Scoreboard bench for aes_decrypt: FIPS-197 vectors, restart/sticky behaviour,
// a round trip through a forward-cipher model and an asynchronous abort.
module tb_aes_decrypt;

   logic               eph1;
   logic               reset;
   logic               ready;
   logic [15:0][7:0]   cipher;
   logic [1:0]         key_size;
   logic [15:1][127:0] key_words;
   logic               fin_flag_r;
   logic [127:0]       plain_out;

   aes_decrypt dut (
      .eph1       (eph1),
      .reset      (reset),
      .ready      (ready),
      .cipher     (cipher),
      .key_size   (key_size),
      .key_words  (key_words),
      .fin_flag_r (fin_flag_r),
      .plain_out  (plain_out)
   );

   localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] PT_RT  = 128'h27ECB2E3A5EE3894885B5289307400E3;

   typedef struct {
      logic [127:0] plain;
      int           done_cyc;
      string        name;
   } exp_t;

   exp_t         sb[$];
   int           n_vec = 0;
   int           n_err = 0;
   int           cyc   = 0;
   logic         fin_prev = 1'b0;
   logic [7:0]   sbox [256];
   logic [31:0]  w [60];
   logic [127:0] rk [15];

   initial begin
      eph1 = 1'b0;
      forever #5 eph1 = ~eph1;
   end

   always @(posedge eph1) cyc++;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] t_xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] t_gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = t_xtime(aa);
      end
      return p;
   endfunction

   // Forward S-box: brute-force inverse followed by the forward affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (t_gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subword(input logic [31:0] t);
      return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
   endfunction

   // Key 00 01 02 ... of nk words; loads rk[] and the key_words bus.
   task automatic expand(input int nk);
      int         nr = nk + 6;
      logic [7:0] rc = 8'h01;
      logic [31:0] t;
      for (int i = 0; i < nk; i++)
         w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = t_xtime(rc);
         end else if (nk > 6 && i % nk == 4) begin
            t = subword(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      key_words = '0;
      for (int r = 0; r <= nr; r++) begin
         rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
         key_words[15-r] = rk[r];
      end
   endtask

   // Forward cipher model standing in for the upstream encryptor.
   function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr);
      logic [127:0] s = pt ^ rk[0];
      logic [127:0] t;
      logic [7:0]   a0, a1, a2, a3;
      for (int rnd = 1; rnd <= nr; rnd++) begin
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               t[127-8*(r+4*c) -: 8] = sbox[s[127-8*(r+4*((c+r)%4)) -: 8]];
         s = t;
         if (rnd != nr) begin
            for (int c = 0; c < 4; c++) begin
               a0 = t[127-32*c -: 8];
               a1 = t[119-32*c -: 8];
               a2 = t[111-32*c -: 8];
               a3 = t[103-32*c -: 8];
               s[127-32*c -: 8] = t_gmul(a0, 8'h02) ^ t_gmul(a1, 8'h03) ^ a2 ^ a3;
               s[119-32*c -: 8] = a0 ^ t_gmul(a1, 8'h02) ^ t_gmul(a2, 8'h03) ^ a3;
               s[111-32*c -: 8] = a0 ^ a1 ^ t_gmul(a2, 8'h02) ^ t_gmul(a3, 8'h03);
               s[103-32*c -: 8] = t_gmul(a0, 8'h03) ^ a1 ^ a2 ^ t_gmul(a3, 8'h02);
            end
         end
         s = s ^ rk[rnd];
      end
      return s;
   endfunction

   // Raises ready at a falling edge; the following rising edge is the start edge.
   task automatic start_op(input string name, input int nr, input logic [1:0] ks,
                           input logic [127:0] ct, input logic [127:0] exp);
      @(negedge eph1);
      cipher   = ct;
      key_size = ks;
      ready    = 1'b1;
      sb.push_back('{exp, cyc + 1 + nr, name});
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      @(negedge eph1);
      while (!fin_flag_r && n < 40) begin
         @(negedge eph1);
         n++;
      end
      check({name, "_timeout"}, fin_flag_r, 1'b1);
   endtask

   always @(negedge eph1) begin
      exp_t e;
      if (reset && fin_flag_r && !fin_prev) begin
         if (sb.size() == 0) begin
            check("spurious_done", fin_flag_r, 1'b0);
         end else begin
            e = sb.pop_front();
            check({e.name, "_plain"}, plain_out, e.plain);
            check({e.name, "_cycle"}, cyc, e.done_cyc);
         end
      end
      fin_prev = fin_flag_r;
   end

   initial begin
      logic [127:0] ct_rt;
      logic [127:0] held;
      int           e0;
      reset     = 1'b1;
      ready     = 1'b0;
      cipher    = '0;
      key_size  = 2'b00;
      key_words = '0;
      build_sbox();
      #2 reset = 1'b0;
      #1;
      check("reset_fin", fin_flag_r, 1'b0);
      check("reset_plain", plain_out, '0);
      repeat (2) @(negedge eph1);
      reset = 1'b1;

      expand(4);
      start_op("aes128", 10, 2'b00, CT128, PT);
      @(posedge eph1) #1 check("aes128_fin_low", fin_flag_r, 1'b0);
      wait_done("aes128");
      held = plain_out;
      repeat (5) @(negedge eph1);
      check("sticky_fin", fin_flag_r, 1'b1);
      check("sticky_plain", plain_out, held);

      @(negedge eph1) ready = 1'b0;
      expand(6);
      start_op("aes192", 12, 2'b01, CT192, PT);
      @(posedge eph1) #1 check("restart_fin_drop", fin_flag_r, 1'b0);
      repeat (3) @(negedge eph1);
      ready = 1'b0;
      @(negedge eph1) ready = 1'b1;
      wait_done("aes192");

      @(negedge eph1) ready = 1'b0;
      expand(8);
      start_op("aes256_10", 14, 2'b10, CT256, PT);
      wait_done("aes256_10");
      @(negedge eph1) ready = 1'b0;
      start_op("aes256_11", 14, 2'b11, CT256, PT);
      wait_done("aes256_11");

      @(negedge eph1) ready = 1'b0;
      ct_rt = encrypt(PT_RT, 14);
      repeat (14) @(negedge eph1);
      start_op("round_trip", 14, 2'b10, ct_rt, PT_RT);
      wait_done("round_trip");
      repeat (3) @(negedge eph1);
      check("round_trip_sticky", fin_flag_r, 1'b1);

      @(negedge eph1) ready = 1'b0;
      start_op("abort", 14, 2'b10, CT256, PT);
      e0 = cyc + 1;
      while (cyc < e0 + 5) @(posedge eph1);
      #2 reset = 1'b0;
      sb.delete();
      #1;
      check("abort_fin", fin_flag_r, 1'b0);
      check("abort_plain", plain_out, '0);
      repeat (2) @(negedge eph1);
      reset = 1'b1;
      sb.push_back('{PT, cyc + 1 + 14, "post_reset"});
      wait_done("post_reset");

      repeat (3) @(negedge eph1);
      check("sb_drain", 128'(sb.size()), '0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
